// File: rtl/pipe_trace_if.sv
// Control, event and readback signals of the pipeline trace buffer.
interface pipe_trace_if #(
   parameter int CH    = 4,
   parameter int W     = 16,
   parameter int DEPTH = 16,
   parameter int CW    = 16
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = CW + CH + CH * W;

   logic            arm_i;
   logic [1:0]      mode_i;
   logic            trig_i;
   logic [AW:0]     post_i;
   logic [CH-1:0]   ev_v_i;
   logic [CH*W-1:0] ev_d_i;
   logic [AW-1:0]   rd_addr_i;
   logic [RW-1:0]   rd_data_o;
   logic [AW:0]     count_o;
   logic [1:0]      state_o;
   logic            done_o;
   logic            overflow_o;

   modport master (
      output arm_i, mode_i, trig_i, post_i, ev_v_i, ev_d_i, rd_addr_i,
      input  rd_data_o, count_o, state_o, done_o, overflow_o
   );

   modport slave (
      input  arm_i, mode_i, trig_i, post_i, ev_v_i, ev_d_i, rd_addr_i,
      output rd_data_o, count_o, state_o, done_o, overflow_o
   );
endinterface

// File: rtl/pipe_trace.sv
// Circular trace buffer for pipeline event taps with cycle stamps,
// continuous / stop-when-full / triggered capture and oldest-first readback.
//
// state   | meaning
// IDLE    | out of reset, nothing captured, stamp frozen
// CAPTURE | recording valid event cycles, waiting for full or trigger
// POST    | trigger accepted, recording the remaining post-trigger records
// DONE    | capture finished, buffer frozen until the next arm
module pipe_trace #(
   parameter int CH    = 4,
   parameter int W     = 16,
   parameter int DEPTH = 16,
   parameter int CW    = 16
) (
   input logic         clk,
   input logic         rst,
   pipe_trace_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = CW + CH + CH * W;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST = FULL - 1'b1;
   localparam logic [AW:0] ONE  = (AW+1)'(1);
   localparam logic [1:0]  MODE_CONT = 2'b00;
   localparam logic [1:0]  MODE_FULL = 2'b01;
   localparam logic [1:0]  MODE_TRIG = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CAPTURE = 2'b01,
      POST    = 2'b10,
      DONE    = 2'b11
   } state_t;

   state_t        state;
   logic [1:0]    mode_q;
   logic [AW-1:0] wptr;
   logic [AW:0]   cnt;
   logic [AW:0]   remaining;
   logic [CW-1:0] stamp;
   logic          ovf;
   logic          done_q;
   logic [RW-1:0] rd_q;
   logic [RW-1:0] mem [DEPTH];

   logic          active;
   logic          wr_en;
   logic [RW-1:0] rec;
   logic [AW:0]   cnt_nxt;
   logic [AW-1:0] wptr_nxt;
   logic [AW-1:0] phys;
   logic [RW-1:0] rd_nxt;

   assign active = (state == CAPTURE) || (state == POST);
   // Arm has priority and never writes, so the arm cycle is excluded here.
   assign wr_en  = active && (|bus.ev_v_i) && !bus.arm_i;
   assign rec    = {stamp, bus.ev_v_i, bus.ev_d_i};

   // Read path looks at post-edge pointer/count and forwards the record being
   // written this cycle, so a same-cycle read of a fresh slot sees new data.
   always_comb begin
      cnt_nxt  = cnt;
      wptr_nxt = wptr;
      if (bus.arm_i) begin
         cnt_nxt  = '0;
         wptr_nxt = '0;
      end else if (wr_en) begin
         wptr_nxt = wptr + 1'b1;
         if (cnt != FULL)
            cnt_nxt = cnt + 1'b1;
      end
      phys = ((cnt_nxt == FULL) ? wptr_nxt : '0) + bus.rd_addr_i;
      if ({1'b0, bus.rd_addr_i} >= cnt_nxt)
         rd_nxt = '0;
      else if (wr_en && (phys == wptr))
         rd_nxt = rec;
      else
         rd_nxt = mem[phys];
   end

   // Record storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr] <= rec;
   end

   // Capture FSM, pointers, stamp and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         mode_q    <= MODE_CONT;
         wptr      <= '0;
         cnt       <= '0;
         remaining <= '0;
         stamp     <= '0;
         ovf       <= 1'b0;
         done_q    <= 1'b0;
         rd_q      <= '0;
      end else begin
         rd_q <= rd_nxt;
         wptr <= wptr_nxt;
         cnt  <= cnt_nxt;
         if (bus.arm_i) begin
            state     <= CAPTURE;
            mode_q    <= (bus.mode_i == 2'b11) ? MODE_CONT : bus.mode_i;
            stamp     <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            done_q    <= 1'b0;
         end else begin
            if (active && (stamp != '1))
               stamp <= stamp + 1'b1;
            if (wr_en && (cnt == FULL))
               ovf <= 1'b1;
            case (state)
               CAPTURE: begin
                  if ((mode_q == MODE_FULL) && wr_en && (cnt == LAST)) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else if ((mode_q == MODE_TRIG) && bus.trig_i) begin
                     if (bus.post_i == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                     end else begin
                        state     <= POST;
                        remaining <= bus.post_i;
                     end
                  end
               end
               POST: begin
                  if (wr_en) begin
                     remaining <= remaining - 1'b1;
                     if (remaining == ONE) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rd_data_o  = rd_q;
   assign bus.count_o    = cnt;
   assign bus.state_o    = state;
   assign bus.done_o     = done_q;
   assign bus.overflow_o = ovf;
endmodule
